pkt_read_master: RTL and testbench

- Downstream consumer of slave_device; drives its read-address interface and reassembles each packet into a 16-bit header plus a payload byte stream.
- Per packet: raises ram_rd_rq, walks rd_addr 0,1,2..PLEN+1 and captures data_o after the fixed slave latency.
- Checks header continuity, then hands payload bytes to the next stage over a valid/ready interface, with a skid FIFO to absorb in-flight reads.

---
 rtl/pkt_read_master.sv | 185 ++++++++++++++++++
 tb/tb_pkt_read_master.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pkt_read_master.sv
// Read master for slave_device: fetches header + payload per packet and streams payload through a skid FIFO.
// Optional MASTER_RD_CSUM_EN adds csum_o/csum_valid (mod-256 payload sum, valid with done).
module pkt_read_master #(
    parameter int RD_LAT     = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int LEN_W      = 8
) (
    input  logic             clk,
    input  logic             rst_l,
    input  logic             start,
    input  logic [LEN_W-1:0] pkt_len,
    output logic             ram_rd_rq,
    output logic [15:0]      rd_addr,
    input  logic [7:0]       data_i,
    output logic [15:0]      hdr_o,
    output logic             hdr_valid,
    output logic             hdr_err,
    output logic [7:0]       pay_data,
    output logic             pay_valid,
    input  logic             pay_ready,
    output logic             busy,
    output logic             done
`ifdef MASTER_RD_CSUM_EN
    ,
    output logic [7:0]       csum_o,
    output logic             csum_valid
`endif
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_HDR, S_PAY, S_DRAIN} state_t;
    typedef enum logic [1:0] {C_HI, C_LO, C_PAY} cls_t;

    state_t        state;
    logic [15:0]   last_addr;
    logic          vld_p [0:RD_LAT];
    cls_t          cls_p [0:RD_LAT];
    logic [7:0]    mem [0:FIFO_DEPTH-1];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic [7:0]    prev_lo;
    logic          first_pkt;

    logic push, pop, start_acc, can_issue, drain_pend;
    int   inflight;

    function automatic logic hdr_seq_ok(input logic [7:0] prev, input logic [7:0] cur);
        return cur == 8'(prev + 8'd1);
    endfunction

    assign start_acc = (state == S_IDLE) && start;
    assign push      = vld_p[RD_LAT] && (cls_p[RD_LAT] == C_PAY);
    assign pop       = pay_valid && pay_ready;
    assign pay_valid = (count != '0);
    assign pay_data  = mem[rd_ptr];

    // Credit: a payload read may issue only if a FIFO slot is reserved for it, counting every payload tag still in flight.
    always_comb begin
        inflight   = 0;
        drain_pend = 1'b0;
        for (int i = 0; i <= RD_LAT; i++)
            if (vld_p[i] && (cls_p[i] == C_PAY)) inflight = inflight + 1;
        for (int i = 0; i < RD_LAT; i++)
            drain_pend = drain_pend | vld_p[i];
        can_issue = (FIFO_DEPTH - int'(count) - inflight) > 0;
    end

    // Issue stage: vld_p[0]/cls_p[0] describe the address on the bus this cycle
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state     <= S_IDLE;
            ram_rd_rq <= 1'b0;
            rd_addr   <= '0;
            last_addr <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
`ifdef MASTER_RD_CSUM_EN
            csum_valid <= 1'b0;
`endif
            for (int i = 0; i <= RD_LAT; i++) begin
                vld_p[i] <= 1'b0;
                cls_p[i] <= C_HI;
            end
        end else begin
            done     <= 1'b0;
`ifdef MASTER_RD_CSUM_EN
            csum_valid <= 1'b0;
`endif
            vld_p[0] <= 1'b0;
            cls_p[0] <= C_HI;
            for (int i = 1; i <= RD_LAT; i++) begin
                vld_p[i] <= vld_p[i-1];
                cls_p[i] <= cls_p[i-1];
            end
            case (state)
                S_IDLE: if (start) begin
                    last_addr <= 16'(pkt_len) + 16'd1;
                    busy      <= 1'b1;
                    ram_rd_rq <= 1'b1;
                    rd_addr   <= '0;
                    vld_p[0]  <= 1'b1;
                    cls_p[0]  <= C_HI;
                    state     <= S_HDR;
                end
                S_HDR: begin
                    rd_addr  <= 16'd1;
                    vld_p[0] <= 1'b1;
                    cls_p[0] <= C_LO;
                    state    <= S_PAY;
                end
                S_PAY: begin
                    if (rd_addr == last_addr) begin
                        ram_rd_rq <= 1'b0;
                        rd_addr   <= '0;
                        state     <= S_DRAIN;
                    end else if (can_issue) begin
                        rd_addr  <= rd_addr + 16'd1;
                        vld_p[0] <= 1'b1;
                        cls_p[0] <= C_PAY;
                    end
                end
                S_DRAIN: if (!drain_pend) begin
                    // Last tag is being captured this edge, so done lines up with its FIFO entry
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_IDLE;
`ifdef MASTER_RD_CSUM_EN
                    csum_valid <= 1'b1;
`endif
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Capture stage: vld_p[RD_LAT] marks the byte currently on data_i
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            hdr_o     <= '0;
            hdr_valid <= 1'b0;
            hdr_err   <= 1'b0;
            prev_lo   <= '0;
            first_pkt <= 1'b1;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
`ifdef MASTER_RD_CSUM_EN
            csum_o <= '0;
`endif
        end else begin
            hdr_valid <= 1'b0;
            if (vld_p[RD_LAT]) begin
                case (cls_p[RD_LAT])
                    C_HI: hdr_o[15:8] <= data_i;
                    C_LO: begin
                        hdr_o[7:0] <= data_i;
                        hdr_valid  <= 1'b1;
                        if (!first_pkt && !hdr_seq_ok(prev_lo, data_i)) hdr_err <= 1'b1;
                        prev_lo    <= data_i;
                        first_pkt  <= 1'b0;
                    end
                    default: ;
                endcase
            end
            if (push) begin
                mem[wr_ptr] <= data_i;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            if (push && !pop)      count <= count + CW'(1);
            else if (!push && pop) count <= count - CW'(1);
`ifdef MASTER_RD_CSUM_EN
            if (start_acc)  csum_o <= '0;
            else if (push)  csum_o <= csum_o + data_i;
`endif
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_l)
        !(push && !pop && (count == CW'(FIFO_DEPTH))));

endmodule

// File: tb/tb_pkt_read_master.sv
// Self-checking bench for pkt_read_master: slave model, queue-based reference model, directed + random packets.
module tb_pkt_read_master;
    localparam int RD_LAT = 2, FIFO_DEPTH = 4, LEN_W = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_l = 1'b0, start = 1'b0, pay_ready = 1'b0;
    logic [LEN_W-1:0] pkt_len = '0;
    logic ram_rd_rq, hdr_valid, hdr_err, pay_valid, busy, done;
    logic [15:0] rd_addr, hdr_o;
    logic [7:0] data_i, pay_data;
`ifdef MASTER_RD_CSUM_EN
    logic [7:0] csum_o;
    logic csum_valid;
`endif

    pkt_read_master #(.RD_LAT(RD_LAT), .FIFO_DEPTH(FIFO_DEPTH), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst_l(rst_l), .start(start), .pkt_len(pkt_len),
        .ram_rd_rq(ram_rd_rq), .rd_addr(rd_addr), .data_i(data_i),
        .hdr_o(hdr_o), .hdr_valid(hdr_valid), .hdr_err(hdr_err),
        .pay_data(pay_data), .pay_valid(pay_valid), .pay_ready(pay_ready),
        .busy(busy), .done(done)
`ifdef MASTER_RD_CSUM_EN
        , .csum_o(csum_o), .csum_valid(csum_valid)
`endif
    );

    // Slave: address register then output register
    logic [7:0]  slave_mem [0:511];
    logic [15:0] sl_addr = '0;
    logic [7:0]  sl_data = '0;
    always @(posedge clk) begin
        if (ram_rd_rq) sl_addr <= rd_addr;
        sl_data <= slave_mem[sl_addr[8:0]];
    end
    assign data_i = sl_data;

    int total = 0, bad = 0;
    logic [7:0]  exp_pay[$];
    logic [15:0] exp_hdr[$];
    logic        exp_err_q[$];
    logic [7:0]  exp_csum_q[$];
    logic        m_first = 1'b1, m_err = 1'b0;
    logic [7:0]  m_prev = '0;
    logic [7:0]  pay_buf [0:255];
    int cur_plen = 0, n_done = 0, n_hdr = 0;
    bit chk_en = 0, rand_rdy = 0;
    logic prev_rq = 1'b0;
    logic [15:0] prev_addr = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: a packet is header {mem0,mem1}, payload mem2..PLEN+1, sticky continuity error, mod-256 sum
    task automatic launch(input int plen, input logic [7:0] hi, input logic [7:0] lo);
        logic [7:0] sum;
        sum = '0;
        slave_mem[0] = hi;
        slave_mem[1] = lo;
        for (int i = 0; i < plen; i++) begin
            slave_mem[2+i] = pay_buf[i];
            exp_pay.push_back(pay_buf[i]);
            sum = sum + pay_buf[i];
        end
        exp_hdr.push_back({hi, lo});
        if (!m_first && lo != 8'(m_prev + 8'd1)) m_err = 1'b1;
        m_prev  = lo;
        m_first = 1'b0;
        exp_err_q.push_back(m_err);
        exp_csum_q.push_back(sum);
        cur_plen = plen;
        @(posedge clk); #1;
        pkt_len = LEN_W'(plen);
        start   = 1'b1;
        @(posedge clk); #1;
        start   = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_done(input int limit, output int n);
        n = 0;
        while (!done && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (!done) check("done_timeout", done, 1);
    endtask

    task automatic do_reset();
        chk_en = 0;
        rst_l  = 1'b0;
        start  = 1'b0;
        repeat (3) @(posedge clk);
        exp_pay.delete(); exp_hdr.delete(); exp_err_q.delete(); exp_csum_q.delete();
        m_first = 1'b1; m_err = 1'b0; m_prev = '0;
        #1 rst_l = 1'b1;
        @(negedge clk);
        chk_en = 1;
    endtask

    task automatic chk_reset_vals(input string tag);
        check({tag, "_rq"}, ram_rd_rq, 0);
        check({tag, "_addr"}, rd_addr, 0);
        check({tag, "_hdr"}, hdr_o, 0);
        check({tag, "_hvld"}, hdr_valid, 0);
        check({tag, "_herr"}, hdr_err, 0);
        check({tag, "_pvld"}, pay_valid, 0);
        check({tag, "_pdata"}, pay_data, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
`ifdef MASTER_RD_CSUM_EN
        check({tag, "_csum"}, csum_o, 0);
        check({tag, "_csvld"}, csum_valid, 0);
`endif
    endtask

    // Compare process: every cycle out of reset
    always @(negedge clk) begin
        if (!rst_l || !chk_en) begin
            prev_rq = 1'b0;
        end else begin
            if (ram_rd_rq) begin
                if (!prev_rq) check("addr_first", rd_addr, 0);
                else if (rd_addr != prev_addr) check("addr_step", rd_addr, prev_addr + 16'd1);
                check("addr_range", 32'(rd_addr) <= 32'(cur_plen + 1), 1);
                check("rq_busy", busy, 1);
            end else begin
                check("addr_idle", rd_addr, 0);
            end
            prev_rq   = ram_rd_rq;
            prev_addr = rd_addr;
            if (pay_valid && pay_ready) begin
                if (exp_pay.size() == 0) check("pay_unexpected", pay_valid, 0);
                else check("pay_data", pay_data, exp_pay.pop_front());
            end
            if (hdr_valid) begin
                n_hdr++;
                if (exp_hdr.size() == 0) check("hdr_unexpected", hdr_valid, 0);
                else check("hdr_o", hdr_o, exp_hdr.pop_front());
            end
`ifdef MASTER_RD_CSUM_EN
            check("csum_valid_align", csum_valid, done);
`endif
            if (done) begin
                n_done++;
                if (exp_err_q.size() == 0) check("done_unexpected", done, 0);
                else begin
                    check("hdr_err_at_done", hdr_err, exp_err_q.pop_front());
                    check("busy_at_done", busy, 0);
`ifdef MASTER_RD_CSUM_EN
                    check("csum_o", csum_o, exp_csum_q.pop_front());
`else
                    void'(exp_csum_q.pop_front());
`endif
                end
            end
        end
    end

    initial forever begin
        @(posedge clk); #1;
        if (rand_rdy) pay_ready = ($urandom_range(0, 3) != 0);
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, d0, h0;
        logic [7:0] lo;
        for (int i = 0; i < 512; i++) slave_mem[i] = 8'(i * 7 + 3);

        // Reset state and the basic 4-byte packet
        pay_ready = 1'b1;
        do_reset();
        chk_reset_vals("rst");
        pay_buf[0] = 8'hA0; pay_buf[1] = 8'hA1; pay_buf[2] = 8'hA2; pay_buf[3] = 8'hA3;
        h0 = n_hdr;
        launch(4, 8'h12, 8'h34);
        check("d1_rq", ram_rd_rq, 1);
        check("d1_addr", rd_addr, 0);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            check("d1_rq", ram_rd_rq, 1);
            check("d1_addr", rd_addr, k);
        end
        wait_done(20, n);
        check("d1_done_lat", n, RD_LAT + 1);
        check("d1_hdr_lit", hdr_o, 16'h1234);
        check("d1_hdr_cnt", n_hdr - h0, 1);
        repeat (4) @(negedge clk);
        check("d1_drained", exp_pay.size(), 0);

        // Back-to-back one-byte packets across the 0xFF->0x00 wrap
        do_reset();
        for (int p = 0; p < 4; p++) begin
            lo = 8'(8'hFD + p);
            pay_buf[0] = 8'(p + 8'h50);
            launch(1, 8'h77, lo);
            wait_done(20, n);
            check("d2_lo", hdr_o[7:0], lo);
        end
        check("d2_err", hdr_err, 0);
        check("d2_lo_wrap", hdr_o[7:0], 8'h00);

        // Continuity break 0x05 -> 0x07 is sticky
        do_reset();
        pay_buf[0] = 8'h11;
        launch(1, 8'h01, 8'h05); wait_done(20, n);
        check("d3_err_p1", hdr_err, 0);
        launch(1, 8'h01, 8'h07); wait_done(20, n);
        check("d3_err_p2", hdr_err, 1);
        launch(1, 8'h01, 8'h08); wait_done(20, n);
        launch(1, 8'h01, 8'h09); wait_done(20, n);
        check("d3_err_sticky", hdr_err, 1);

        // Backpressure: FIFO fills to 4, issue stalls, then all 10 bytes drain
        do_reset();
        pay_ready = 1'b0;
        for (int i = 0; i < 10; i++) pay_buf[i] = 8'($urandom);
        d0 = n_done;
        launch(10, 8'h20, 8'h40);
        repeat (30) @(negedge clk);
        check("d4_stall_addr", rd_addr, 5);
        check("d4_stall_rq", ram_rd_rq, 1);
        check("d4_stall_busy", busy, 1);
        check("d4_stall_pvld", pay_valid, 1);
        check("d4_stall_head", pay_data, pay_buf[0]);
        check("d4_none_taken", exp_pay.size(), 10);
        @(posedge clk); #1 pay_ready = 1'b1;
        wait_done(100, n);
        repeat (6) @(negedge clk);
        check("d4_all_out", exp_pay.size(), 0);
        check("d4_done_once", n_done - d0, 1);

        // Header-only packet
        d0 = n_done;
        launch(0, 8'h21, 8'h41);
        check("d5_a0", rd_addr, 0);
        @(negedge clk);
        check("d5_rq1", ram_rd_rq, 1);
        check("d5_a1", rd_addr, 1);
        @(negedge clk);
        check("d5_rq_off", ram_rd_rq, 0);
        wait_done(20, n);
        repeat (2) @(negedge clk);
        check("d5_done_once", n_done - d0, 1);
        check("d5_no_pay", pay_valid, 0);

        // Asynchronous reset in the middle of the payload phase
        pay_ready = 1'b0;
        for (int i = 0; i < 8; i++) pay_buf[i] = 8'($urandom);
        launch(8, 8'h22, 8'h42);
        repeat (4) @(negedge clk);
        check("d6_in_pay", rd_addr >= 16'd2, 1);
        chk_en = 0;
        #2 rst_l = 1'b0;
        #1 chk_reset_vals("midrst");
        pay_ready = 1'b1;
        do_reset();

`ifdef MASTER_RD_CSUM_EN
        pay_buf[0] = 8'h80; pay_buf[1] = 8'h90; pay_buf[2] = 8'h10;
        launch(3, 8'h01, 8'h02);
        wait_done(20, n);
        check("d7_csum_lit", csum_o, 8'h20);
        check("d7_csum_vld", csum_valid, 1);
`endif

        // Randomised packets with random backpressure
        do_reset();
        rand_rdy = 1;
        for (int p = 0; p < 40; p++) begin
            int plen;
            plen = $urandom_range(0, 20);
            for (int i = 0; i < plen; i++) pay_buf[i] = 8'($urandom);
            if (m_first || $urandom_range(0, 7) == 0) lo = 8'($urandom);
            else lo = 8'(m_prev + 8'd1);
            launch(plen, 8'($urandom), lo);
            wait_done(400, n);
        end
        rand_rdy = 0;
        @(posedge clk); #1 pay_ready = 1'b1;
        n = 0;
        while (exp_pay.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("rnd_pay_left", exp_pay.size(), 0);
        check("rnd_hdr_left", exp_hdr.size(), 0);
        check("rnd_done_left", exp_err_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
